// File: rtl/calc_pkg.sv
// calc_pkg
// Shared types and default sizing for the calculator's serial transmit path.
//   tx_state_t   : transmitter FSM states (IDLE, LOADED, SHIFT, DONE)
//   CALC_DATA_W  : default width of a transmitted result word
//   CALC_CLK_DIV : default number of system clocks per serial bit
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOADED,
    SHIFT,
    DONE
  } tx_state_t;

  localparam int CALC_DATA_W  = 16;
  localparam int CALC_CLK_DIV = 4;

endpackage

// File: rtl/serial_transceiver_bit_rate_gen.sv
// bit_rate_gen
// Divides the system clock down to the serial bit rate while a transfer is
// in progress. The prescaler runs only while enabled and sits at zero
// otherwise, so every frame starts on a fresh bit boundary.
// Ports:
//   Clk, Reset : system clock, asynchronous active-high reset
//   en         : high while the transmitter is shifting
//   bit_end    : one-cycle pulse on the last clock of each bit period
//   sclk       : serial bit clock, low for the first half of a bit, high
//                for the second half
module bit_rate_gen
  import calc_pkg::*;
#(
  parameter int CLK_DIV = CALC_CLK_DIV
) (
  input  logic Clk,
  input  logic Reset,
  input  logic en,
  output logic bit_end,
  output logic sclk
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(CLK_DIV / 2);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  logic [PRE_W-1:0] pre_d, pre_q;

  // Counts 0..CLK_DIV-1 and wraps; any cycle without enable forces it back
  // to zero so a new frame always begins at the start of a bit.
  always_comb begin
    pre_d = '0;
    if (en && (pre_q != PRE_LAST)) begin
      pre_d = pre_q + PRE_ONE;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign bit_end = en && (pre_q == PRE_LAST);
  assign sclk    = en && (pre_q >= PRE_HALF);

endmodule

// File: rtl/serial_transceiver.sv
// serial_transceiver
// Parallel-to-serial transmit stage behind the calculator's read/write flow
// controller. A result word is captured on SampleData and sent MSB first on
// a framed serial link once TxData is seen; TxDone then stays high until
// the next word is sampled, which lets the controller return to idle.
// Ports:
//   Clk, Reset  : system clock, asynchronous active-high reset
//   DIn         : word to transmit, captured when SampleData is high
//   SampleData  : load DIn into the shift register
//   TxData      : start sending the loaded word (level, may be held)
//   SOut        : serial data, MSB first, zero outside a frame
//   SClk        : serial bit clock, receiver samples on its rising edge
//   SFrame      : high while bits are on SOut
//   TxBusy      : high while shifting (same as SFrame)
//   TxDone      : high from end of a frame until the next SampleData
module serial_transceiver
  import calc_pkg::*;
#(
  parameter int DATA_W  = CALC_DATA_W,
  parameter int CLK_DIV = CALC_CLK_DIV
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] DIn,
  input  logic              SampleData,
  input  logic              TxData,
  output logic              SOut,
  output logic              SClk,
  output logic              SFrame,
  output logic              TxBusy,
  output logic              TxDone
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  tx_state_t         state_d, state_q;
  logic [DATA_W-1:0] shreg_d, shreg_q;
  logic [CNT_W-1:0]  bitcnt_d, bitcnt_q;
  logic              shifting;
  logic              bit_end;
  logic              sclk_int;

  assign shifting = (state_q == SHIFT);

  bit_rate_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_rate_gen (
    .Clk     (Clk),
    .Reset   (Reset),
    .en      (shifting),
    .bit_end (bit_end),
    .sclk    (sclk_int)
  );

  // Sampling wins over starting in LOADED so the controller can always
  // refresh the word. Once DONE, a still-held TxData is ignored: only a new
  // sample re-arms the transmitter, so a frame is never repeated.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    unique case (state_q)
      IDLE: begin
        if (SampleData) begin
          state_d = LOADED;
          shreg_d = DIn;
        end
      end
      LOADED: begin
        if (SampleData) begin
          shreg_d = DIn;
        end else if (TxData) begin
          state_d  = SHIFT;
          bitcnt_d = CNT_LAST;
        end
      end
      SHIFT: begin
        if (bit_end) begin
          if (bitcnt_q == '0) begin
            state_d = DONE;
          end else begin
            shreg_d  = {shreg_q[DATA_W-2:0], 1'b0};
            bitcnt_d = bitcnt_q - CNT_ONE;
          end
        end
      end
      DONE: begin
        if (SampleData) begin
          state_d = LOADED;
          shreg_d = DIn;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  // All outputs decode registered state only, so reset clears them at once.
  assign SOut   = shifting & shreg_q[DATA_W-1];
  assign SClk   = sclk_int;
  assign SFrame = shifting;
  assign TxBusy = shifting;
  assign TxDone = (state_q == DONE);

endmodule

// File: tb/tb_serial_transceiver.sv
// tb_serial_transceiver
// Scoreboarded bench for serial_transceiver. Stimulus pushes each word that
// must appear on the link into exp_q; an independent monitor watches the
// serial pins, checks every in-frame cycle against the bit position derived
// from the cycle count, reassembles the word on SClk rising edges and
// compares it with the head of the queue when the frame closes.
module tb_serial_transceiver;

  localparam int DATA_W    = 16;
  localparam int CLK_DIV   = 4;
  localparam int FRAME_CYC = DATA_W * CLK_DIV;

  logic              Clk;
  logic              Reset;
  logic [DATA_W-1:0] DIn;
  logic              SampleData;
  logic              TxData;
  logic              SOut;
  logic              SClk;
  logic              SFrame;
  logic              TxBusy;
  logic              TxDone;

  int total;
  int bad;

  logic [DATA_W-1:0] exp_q[$];

  serial_transceiver #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .DIn        (DIn),
    .SampleData (SampleData),
    .TxData     (TxData),
    .SOut       (SOut),
    .SClk       (SClk),
    .SFrame     (SFrame),
    .TxBusy     (TxBusy),
    .TxDone     (TxDone)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Single comparison point; every check in the bench goes through here.
  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor state
  logic              prev_sframe;
  logic              prev_sclk;
  int                frame_len;
  int                rx_bits;
  int                gap;
  logic              have_prev;
  logic [DATA_W-1:0] rx_word;
  logic [DATA_W-1:0] exp_word;
  int                bit_idx;

  initial begin
    prev_sframe = 1'b0;
    prev_sclk   = 1'b0;
    frame_len   = 0;
    rx_bits     = 0;
    gap         = 0;
    have_prev   = 1'b0;
    rx_word     = '0;
  end

  // Monitor: samples on the falling clock edge, away from DUT updates.
  always @(negedge Clk) begin
    if (Reset) begin
      check_output("rst_outputs", {27'd0, SOut, SClk, SFrame, TxBusy, TxDone}, 32'd0);
      prev_sframe = 1'b0;
      prev_sclk   = 1'b0;
      frame_len   = 0;
      rx_bits     = 0;
      gap         = 0;
      have_prev   = 1'b0;
      rx_word     = '0;
    end else begin
      if (SFrame) begin
        if (!prev_sframe) begin
          if (have_prev) check_output("frame_gap_ge2", (gap >= 2) ? 32'd1 : 32'd0, 32'd1);
          check_output("frame_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
          frame_len = 0;
          rx_bits   = 0;
          rx_word   = '0;
        end
        if (exp_q.size() != 0 && frame_len < FRAME_CYC) begin
          exp_word = exp_q[0];
          bit_idx  = frame_len / CLK_DIV;
          check_output("sout_bit", {31'd0, SOut}, {31'd0, exp_word[DATA_W-1-bit_idx]});
          check_output("sclk_phase", {31'd0, SClk},
                       ((frame_len % CLK_DIV) >= CLK_DIV / 2) ? 32'd1 : 32'd0);
          check_output("busy_in_frame", {31'd0, TxBusy}, 32'd1);
          check_output("done_in_frame", {31'd0, TxDone}, 32'd0);
        end else if (frame_len == FRAME_CYC) begin
          check_output("frame_overrun", frame_len + 1, FRAME_CYC);
        end
        if (!prev_sclk && SClk) begin
          rx_word = {rx_word[DATA_W-2:0], SOut};
          rx_bits++;
        end
        frame_len++;
      end else begin
        if (prev_sframe) begin
          check_output("frame_len", frame_len, FRAME_CYC);
          check_output("done_at_frame_end", {31'd0, TxDone}, 32'd1);
          check_output("rx_bits", rx_bits, DATA_W);
          if (exp_q.size() != 0) begin
            check_output("rx_word", {16'd0, rx_word}, {16'd0, exp_q[0]});
            void'(exp_q.pop_front());
          end
          have_prev = 1'b1;
          gap       = 0;
        end
        check_output("idle_outputs", {29'd0, SOut, SClk, TxBusy}, 32'd0);
        gap++;
      end
      prev_sframe = SFrame;
      prev_sclk   = SClk;
    end
  end

  // Waits for TxDone with a bound; elapsed is the number of edges already
  // seen since TxData was raised. TxDone must rise on the FRAME_CYC-th edge
  // after the starting edge, then stay high while TxData is held.
  task automatic wait_done(input int elapsed, input int hold_after);
    int waited;
    waited = elapsed;
    while (!TxDone && waited < FRAME_CYC + 20) begin
      @(posedge Clk); #1;
      waited++;
    end
    check_output("done_latency", waited, FRAME_CYC + 1);
    for (int i = 0; i < hold_after; i++) begin
      @(posedge Clk); #1;
      check_output("done_held", {31'd0, TxDone}, 32'd1);
      check_output("no_retransmit", {31'd0, SFrame}, 32'd0);
    end
    TxData = 1'b0;
  endtask

  // Controller handshake: hold SampleData until TxDone is low, then hold
  // TxData until TxDone is high. Optional extra reloads precede the final
  // word; only the last sampled word may appear on the link.
  task automatic apply_stimulus(input logic [DATA_W-1:0] w, input int reloads, input int hold_after);
    int waited;
    SampleData = 1'b1;
    for (int r = 0; r < reloads; r++) begin
      DIn = DATA_W'($urandom);
      @(posedge Clk); #1;
    end
    DIn    = w;
    waited = 0;
    do begin
      @(posedge Clk); #1;
      waited++;
    end while (TxDone && waited < 10);
    check_output("done_clear", {31'd0, TxDone}, 32'd0);
    SampleData = 1'b0;
    exp_q.push_back(w);
    TxData = 1'b1;
    wait_done(0, hold_after);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sframe_hi;
    int done_hi;
    total      = 0;
    bad        = 0;
    Reset      = 1'b1;
    DIn        = '0;
    SampleData = 1'b0;
    TxData     = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check_output("reset_outputs", {27'd0, SOut, SClk, SFrame, TxBusy, TxDone}, 32'd0);
    Reset = 1'b0;
    @(posedge Clk); #1;

    // TxData alone in IDLE must not start anything.
    TxData = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    check_output("idle_txdata_ignored", {30'd0, SFrame, TxDone}, 32'd0);
    TxData = 1'b0;

    $display("[TB] basic frame with TxData held after done");
    apply_stimulus(16'hA5C3, 0, 20);
    repeat (2) @(posedge Clk);

    $display("[TB] SampleData and TxData together in LOADED");
    DIn        = 16'h5555;
    SampleData = 1'b1;
    @(posedge Clk); #1;
    DIn    = 16'h0001;
    TxData = 1'b1;
    @(posedge Clk); #1;
    check_output("prio_no_frame", {31'd0, SFrame}, 32'd0);
    check_output("prio_no_done", {31'd0, TxDone}, 32'd0);
    SampleData = 1'b0;
    exp_q.push_back(16'h0001);
    wait_done(0, 0);
    repeat (3) @(posedge Clk);

    $display("[TB] SampleData mid-SHIFT is ignored");
    DIn        = 16'h3C5A;
    SampleData = 1'b1;
    @(posedge Clk); #1;
    SampleData = 1'b0;
    exp_q.push_back(16'h3C5A);
    TxData = 1'b1;
    repeat (20) @(posedge Clk);
    #1;
    DIn        = 16'hFFFF;
    SampleData = 1'b1;
    @(posedge Clk); #1;
    SampleData = 1'b0;
    wait_done(21, 0);
    repeat (2) @(posedge Clk);

    $display("[TB] back-to-back words");
    apply_stimulus(16'h1234, 0, 0);
    apply_stimulus(16'h8001, 0, 0);
    repeat (2) @(posedge Clk);

    $display("[TB] randomized words");
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(DATA_W'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
      repeat ($urandom_range(0, 5)) @(posedge Clk);
    end
    #1;

    $display("[TB] reset at bit 7");
    DIn        = 16'hBEEF;
    SampleData = 1'b1;
    @(posedge Clk); #1;
    SampleData = 1'b0;
    exp_q.push_back(16'hBEEF);
    TxData = 1'b1;
    repeat (7 * CLK_DIV + 1) @(posedge Clk);
    #1;
    check_output("mid_frame_active", {31'd0, SFrame}, 32'd1);
    #1;
    exp_q.delete();
    Reset  = 1'b1;
    TxData = 1'b0;
    #1;
    check_output("rst_mid_outputs", {27'd0, SOut, SClk, SFrame, TxBusy, TxDone}, 32'd0);
    repeat (2) @(posedge Clk);
    #1;
    Reset     = 1'b0;
    TxData    = 1'b1;
    sframe_hi = 0;
    done_hi   = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge Clk); #1;
      if (SFrame) sframe_hi++;
      if (TxDone) done_hi++;
    end
    check_output("post_rst_no_frame", sframe_hi, 0);
    check_output("post_rst_no_done", done_hi, 0);
    TxData = 1'b0;

    repeat (5) @(posedge Clk);
    #1;
    check_output("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
